// File: rtl/instr_encoder.sv
// Streaming instruction encoder: packs decoded instruction fields into 16-bit
// controller words and writes them to sequential instruction-memory addresses.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [4:0]         in_mnem,
  input  logic [3:0]         in_ra,
  input  logic [3:0]         in_rb,
  input  logic [3:0]         in_cond,
  input  logic signed [15:0] in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_word,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               done,
  output logic               full,
  output logic               err,
  output logic [7:0]         err_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LP_ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   LP_CNT_ONE  = 1;
  localparam logic [ADDR_W:0]   LP_CAP_M1   = {1'b0, {ADDR_W{1'b1}}};

  state_t              r_state;
  logic                r_out_valid;
  logic [15:0]         r_out_word;
  logic [ADDR_W-1:0]   r_out_addr;
  logic                r_done;
  logic                r_full;
  logic                r_err;
  logic [7:0]          r_err_cnt;
  logic [ADDR_W:0]     r_hs_cnt;
  logic [ADDR_W:0]     r_iss_cnt;

  logic                w_hs;
  logic                w_room;
  logic                w_in_ready;
  logic                w_acc;
  logic                w_emit;
  logic [16:0]         w_enc;

  // ALU sub-op shared by R-type ext field and I-type opcode field
  function automatic logic [3:0] f_alu_code(input logic [4:0] mnem);
    case (mnem)
      5'd0, 5'd7:  f_alu_code = 4'b0001;
      5'd1, 5'd8:  f_alu_code = 4'b0010;
      5'd2, 5'd9:  f_alu_code = 4'b0011;
      5'd3, 5'd10: f_alu_code = 4'b0101;
      5'd4, 5'd11: f_alu_code = 4'b1001;
      5'd5, 5'd12: f_alu_code = 4'b1011;
      default:     f_alu_code = 4'b1101;
    endcase
  endfunction

  // Returns {legal, word}; legal=0 for illegal mnemonics or out-of-range immediates
  function automatic logic [16:0] f_encode(input logic [4:0] mnem, input logic [3:0] ra,
                                           input logic [3:0] rb, input logic [3:0] cond,
                                           input logic signed [15:0] imm);
    logic ok_s8, ok_u8, ok_s4;
    ok_s8 = (&imm[15:7]) | ~(|imm[15:7]);
    ok_u8 = ~(|imm[15:8]);
    ok_s4 = (&imm[15:3]) | ~(|imm[15:3]);
    case (mnem)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6:
        f_encode = {1'b1, 4'b0000, ra, f_alu_code(mnem), rb};
      5'd7, 5'd8, 5'd9, 5'd13:
        f_encode = {ok_u8, f_alu_code(mnem), ra, imm[7:0]};
      5'd10, 5'd11, 5'd12:
        f_encode = {ok_s8, f_alu_code(mnem), ra, imm[7:0]};
      5'd14:   f_encode = {ok_u8, 4'b1111, ra, imm[7:0]};
      5'd15:   f_encode = {1'b1, 4'b1000, ra, 4'b0100, rb};
      5'd16:   f_encode = {ok_s4, 4'b1000, ra, 3'b000, imm[15], imm[3:0]};
      5'd17:   f_encode = {1'b1, 4'b0100, ra, 4'b0000, rb};
      5'd18:   f_encode = {1'b1, 4'b0100, ra, 4'b0100, rb};
      5'd19:   f_encode = {1'b1, 4'b0100, ra, 4'b1000, rb};
      5'd20:   f_encode = {1'b1, 4'b0100, cond, 4'b1100, rb};
      5'd21:   f_encode = {ok_s8, 4'b1100, cond, imm[7:0]};
      default: f_encode = 17'd0;
    endcase
  endfunction

  function automatic logic [7:0] f_sat_inc(input logic [7:0] cnt);
    f_sat_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  // Accepts stop once every address has a word issued, so a wrap never overwrites base
  assign w_hs       = r_out_valid & out_ready;
  assign w_room     = ~r_iss_cnt[ADDR_W];
  assign w_in_ready = (r_state == S_RUN) & (~r_out_valid | out_ready) & ~r_full & w_room;
  assign w_acc      = in_valid & w_in_ready;
  assign w_enc      = f_encode(in_mnem, in_ra, in_rb, in_cond, in_imm);
  assign w_emit     = w_acc & w_enc[16];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_word  <= 16'd0;
      r_out_addr  <= '0;
      r_done      <= 1'b0;
      r_full      <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= 8'd0;
      r_hs_cnt    <= '0;
      r_iss_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      // output register stage: load on emit, release on handshake
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_word  <= w_enc[15:0];
        r_iss_cnt   <= r_iss_cnt + LP_CNT_ONE;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end
      if (w_hs) begin
        r_out_addr <= r_out_addr + LP_ADDR_ONE;
        r_hs_cnt   <= r_hs_cnt + LP_CNT_ONE;
        if (r_hs_cnt == LP_CAP_M1) r_full <= 1'b1;
      end
      if (w_acc & ~w_enc[16]) begin
        r_err     <= 1'b1;
        r_err_cnt <= f_sat_inc(r_err_cnt);
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_RUN;
            r_out_addr <= base_addr;
            r_err      <= 1'b0;
            r_err_cnt  <= 8'd0;
            r_full     <= 1'b0;
            r_hs_cnt   <= '0;
            r_iss_cnt  <= '0;
          end
        end
        S_RUN: begin
          if (r_full) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_acc & in_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (~r_out_valid | w_hs) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign out_addr  = r_out_addr;
  assign done      = r_done;
  assign full      = r_full;
  assign err       = r_err;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed program scenarios on 8-bit and 2-bit address
// instances, then a randomized program scored against a field-level reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, start2;
  logic [7:0]  base8;
  logic [1:0]  base2;
  logic        in_valid, in_last, out_ready;
  logic [4:0]  in_mnem;
  logic [3:0]  in_ra, in_rb, in_cond;
  logic [15:0] in_imm;

  logic        in_ready8, out_valid8, done8, full8, err8;
  logic [15:0] out_word8;
  logic [7:0]  out_addr8, err_count8;
  logic        in_ready2, out_valid2, done2, full2, err2;
  logic [15:0] out_word2;
  logic [1:0]  out_addr2;
  logic [7:0]  err_count2;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int ext_tab [7] = '{1, 2, 3, 5, 9, 11, 13};

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .base_addr(base8),
    .in_valid(in_valid), .in_ready(in_ready8), .in_last(in_last), .in_mnem(in_mnem),
    .in_ra(in_ra), .in_rb(in_rb), .in_cond(in_cond), .in_imm(in_imm),
    .out_valid(out_valid8), .out_ready(out_ready), .out_word(out_word8), .out_addr(out_addr8),
    .done(done8), .full(full8), .err(err8), .err_count(err_count8)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .base_addr(base2),
    .in_valid(in_valid), .in_ready(in_ready2), .in_last(in_last), .in_mnem(in_mnem),
    .in_ra(in_ra), .in_rb(in_rb), .in_cond(in_cond), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_word(out_word2), .out_addr(out_addr2),
    .done(done2), .full(full2), .err(err2), .err_count(err_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit sel2, input logic [7:0] b);
    if (sel2) begin start2 = 1'b1; base2 = b[1:0]; end
    else begin start8 = 1'b1; base8 = b; end
    tick;
    start8 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic send(input bit sel2, input logic [4:0] m, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [3:0] cond, input logic [15:0] imm,
                      input bit last);
    int waited;
    in_mnem = m; in_ra = ra; in_rb = rb; in_cond = cond; in_imm = imm;
    in_last = last; in_valid = 1'b1;
    #1;
    waited = 0;
    while (!(sel2 ? in_ready2 : in_ready8) && waited < 20) begin
      tick;
      waited++;
    end
    if (waited >= 20) chk("send_timeout", 32'(waited), 32'(0));
    tick;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Reference encoder built from the field rules with integer arithmetic
  function automatic void ref_enc(input int m, input int ra, input int rb, input int cond,
                                  input logic [15:0] imm, output bit ok, output int w);
    int v;
    v  = int'($signed(imm));
    ok = 1'b1;
    w  = 0;
    if (m <= 6) w = ra * 256 + ext_tab[m] * 16 + rb;
    else if (m <= 14) begin
      w = ((m == 14) ? 15 : ext_tab[m - 7]) * 4096 + ra * 256 + (v & 255);
      if (m >= 10 && m <= 12) ok = (v >= -128 && v <= 127);
      else ok = (v >= 0 && v <= 255);
    end
    else if (m == 15) w = 'h8000 + ra * 256 + 4 * 16 + rb;
    else if (m == 16) begin
      w  = 'h8000 + ra * 256 + ((v < 0) ? 16 : 0) + (v & 15);
      ok = (v >= -8 && v <= 7);
    end
    else if (m == 17) w = 'h4000 + ra * 256 + rb;
    else if (m == 18) w = 'h4000 + ra * 256 + 4 * 16 + rb;
    else if (m == 19) w = 'h4000 + ra * 256 + 8 * 16 + rb;
    else if (m == 20) w = 'h4000 + cond * 256 + 12 * 16 + rb;
    else if (m == 21) begin
      w  = 'hC000 + cond * 256 + (v & 255);
      ok = (v >= -128 && v <= 127);
    end
    else ok = 1'b0;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] q_word[$];
    logic [7:0]  exp_addr;
    int          exp_err, n_sent, w;
    bit          fin, acc, ok;

    reset = 1'b0; start8 = 1'b0; start2 = 1'b0; base8 = '0; base2 = '0;
    in_valid = 1'b0; in_last = 1'b0; in_mnem = '0; in_ra = '0; in_rb = '0;
    in_cond = '0; in_imm = '0; out_ready = 1'b1;
    repeat (3) tick;
    chk("rst_in_ready", 32'(in_ready8), 32'(0));
    chk("rst_out_valid", 32'(out_valid8), 32'(0));
    chk("rst_done", 32'(done8), 32'(0));
    chk("rst_full", 32'(full8), 32'(0));
    chk("rst_err", 32'(err8), 32'(0));
    chk("rst_out_word", 32'(out_word8), 32'(0));
    chk("rst_out_addr", 32'(out_addr8), 32'(0));
    chk("rst_err_count", 32'(err_count8), 32'(0));
    reset = 1'b1;
    tick;

    // Program 1: ADD then ADDI(last)
    do_start(1'b0, 8'h10);
    chk("p1_start_addr", 32'(out_addr8), 32'h10);
    chk("p1_in_ready", 32'(in_ready8), 32'(1));
    send(1'b0, 5'd3, 4'd3, 4'd5, 4'd0, 16'h0000, 1'b0);
    chk("p1_w0_valid", 32'(out_valid8), 32'(1));
    chk("p1_w0_word", 32'(out_word8), 32'h0355);
    chk("p1_w0_addr", 32'(out_addr8), 32'h10);
    send(1'b0, 5'd10, 4'd2, 4'd0, 4'd0, 16'hFFFF, 1'b1);
    chk("p1_w1_word", 32'(out_word8), 32'h52FF);
    chk("p1_w1_addr", 32'(out_addr8), 32'h11);
    chk("p1_in_ready_drain", 32'(in_ready8), 32'(0));
    chk("p1_done_early", 32'(done8), 32'(0));
    tick;
    chk("p1_done", 32'(done8), 32'(1));
    chk("p1_drained", 32'(out_valid8), 32'(0));
    tick;
    chk("p1_done_one_cycle", 32'(done8), 32'(0));
    chk("p1_err", 32'(err8), 32'(0));
    chk("p1_idle_ready", 32'(in_ready8), 32'(0));

    // Program 2: shift/branch/jump encodings
    do_start(1'b0, 8'h20);
    send(1'b0, 5'd16, 4'd1, 4'd0, 4'd0, 16'hFFFD, 1'b0);
    chk("p2_lshi", 32'(out_word8), 32'h811D);
    chk("p2_lshi_addr", 32'(out_addr8), 32'h20);
    send(1'b0, 5'd21, 4'd0, 4'd0, 4'd0, 16'hFFFE, 1'b0);
    chk("p2_bcond", 32'(out_word8), 32'hC0FE);
    chk("p2_bcond_addr", 32'(out_addr8), 32'h21);
    send(1'b0, 5'd20, 4'd0, 4'd4, 4'd14, 16'h0000, 1'b0);
    chk("p2_jcond", 32'(out_word8), 32'h4EC4);
    chk("p2_jcond_addr", 32'(out_addr8), 32'h22);
    send(1'b0, 5'd19, 4'd15, 4'd6, 4'd0, 16'h0000, 1'b1);
    chk("p2_jal", 32'(out_word8), 32'h4F86);
    chk("p2_jal_addr", 32'(out_addr8), 32'h23);
    tick;
    chk("p2_done", 32'(done8), 32'(1));
    tick;

    // Program 3: rejected instructions consume no address
    do_start(1'b0, 8'h40);
    send(1'b0, 5'd10, 4'd0, 4'd0, 4'd0, 16'd200, 1'b0);
    chk("p3_rej1_valid", 32'(out_valid8), 32'(0));
    chk("p3_rej1_err", 32'(err8), 32'(1));
    chk("p3_rej1_cnt", 32'(err_count8), 32'(1));
    send(1'b0, 5'd25, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0);
    chk("p3_rej2_cnt", 32'(err_count8), 32'(2));
    chk("p3_rej2_addr", 32'(out_addr8), 32'h40);
    send(1'b0, 5'd13, 4'd1, 4'd0, 4'd0, 16'd200, 1'b1);
    chk("p3_movi", 32'(out_word8), 32'hD1C8);
    chk("p3_movi_addr", 32'(out_addr8), 32'h40);
    chk("p3_movi_valid", 32'(out_valid8), 32'(1));
    tick;
    chk("p3_done", 32'(done8), 32'(1));
    chk("p3_err_sticky", 32'(err8), 32'(1));
    tick;

    // Program 4: backpressure hold, then streaming
    out_ready = 1'b0;
    do_start(1'b0, 8'h50);
    chk("p4_err_cleared", 32'(err8), 32'(0));
    chk("p4_errcnt_cleared", 32'(err_count8), 32'(0));
    send(1'b0, 5'd3, 4'd3, 4'd5, 4'd0, 16'h0000, 1'b0);
    in_mnem = 5'd8; in_ra = 4'd1; in_imm = 16'h0033; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("p4_hold_ready", 32'(in_ready8), 32'(0));
      chk("p4_hold_valid", 32'(out_valid8), 32'(1));
      chk("p4_hold_word", 32'(out_word8), 32'h0355);
      chk("p4_hold_addr", 32'(out_addr8), 32'h50);
      tick;
    end
    out_ready = 1'b1;
    #1;
    chk("p4_release_ready", 32'(in_ready8), 32'(1));
    tick;
    in_valid = 1'b0;
    chk("p4_ori", 32'(out_word8), 32'h2133);
    chk("p4_ori_addr", 32'(out_addr8), 32'h51);
    send(1'b0, 5'd9, 4'd2, 4'd0, 4'd0, 16'h000F, 1'b0);
    chk("p4_xori", 32'(out_word8), 32'h320F);
    chk("p4_xori_addr", 32'(out_addr8), 32'h52);
    send(1'b0, 5'd4, 4'd4, 4'd6, 4'd0, 16'h0000, 1'b1);
    chk("p4_sub", 32'(out_word8), 32'h0496);
    chk("p4_sub_addr", 32'(out_addr8), 32'h53);
    tick;
    chk("p4_done", 32'(done8), 32'(1));
    tick;

    // Program 5: 4-entry address space fills and wraps
    do_start(1'b1, 8'h03);
    send(1'b1, 5'd6, 4'd1, 4'd2, 4'd0, 16'h0000, 1'b0);
    chk("p5_w0", 32'(out_word2), 32'h01D2);
    chk("p5_a0", 32'(out_addr2), 32'd3);
    send(1'b1, 5'd0, 4'd3, 4'd4, 4'd0, 16'h0000, 1'b0);
    chk("p5_w1", 32'(out_word2), 32'h0314);
    chk("p5_a1", 32'(out_addr2), 32'd0);
    send(1'b1, 5'd17, 4'd5, 4'd6, 4'd0, 16'h0000, 1'b0);
    chk("p5_w2", 32'(out_word2), 32'h4506);
    chk("p5_a2", 32'(out_addr2), 32'd1);
    send(1'b1, 5'd18, 4'd7, 4'd8, 4'd0, 16'h0000, 1'b0);
    chk("p5_w3", 32'(out_word2), 32'h4748);
    chk("p5_a3", 32'(out_addr2), 32'd2);
    in_mnem = 5'd15; in_ra = 4'd1; in_rb = 4'd1; in_last = 1'b1; in_valid = 1'b1;
    #1;
    chk("p5_5th_not_ready", 32'(in_ready2), 32'(0));
    chk("p5_full_before", 32'(full2), 32'(0));
    tick;
    chk("p5_full", 32'(full2), 32'(1));
    chk("p5_drained", 32'(out_valid2), 32'(0));
    chk("p5_full_ready", 32'(in_ready2), 32'(0));
    tick;
    chk("p5_done", 32'(done2), 32'(1));
    in_valid = 1'b0; in_last = 1'b0;
    tick;
    chk("p5_done_one_cycle", 32'(done2), 32'(0));
    chk("p5_no_reject", 32'(err_count2), 32'(0));

    // Program 6: reset while a word is pending
    out_ready = 1'b0;
    do_start(1'b0, 8'h60);
    send(1'b0, 5'd3, 4'd3, 4'd5, 4'd0, 16'h0000, 1'b0);
    chk("p6_pending", 32'(out_valid8), 32'(1));
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("p6_rst_valid", 32'(out_valid8), 32'(0));
    chk("p6_rst_ready", 32'(in_ready8), 32'(0));
    chk("p6_rst_addr", 32'(out_addr8), 32'(0));
    chk("p6_rst_word", 32'(out_word8), 32'(0));
    out_ready = 1'b1;
    do_start(1'b0, 8'h70);
    send(1'b0, 5'd6, 4'd2, 4'd3, 4'd0, 16'h0000, 1'b1);
    chk("p6_mov", 32'(out_word8), 32'h02D3);
    chk("p6_mov_addr", 32'(out_addr8), 32'h70);
    tick;
    chk("p6_done", 32'(done8), 32'(1));
    tick;

    // Randomized program against the reference model
    exp_addr = 8'($urandom);
    do_start(1'b0, exp_addr);
    exp_err = 0; n_sent = 0; fin = 1'b0;
    q_word.delete();
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (!in_valid && n_sent < 200) begin
        in_mnem = 5'($urandom_range(0, 31));
        in_ra   = 4'($urandom);
        in_rb   = 4'($urandom);
        in_cond = 4'($urandom);
        case ($urandom_range(0, 2))
          0:       in_imm = 16'($urandom);
          1:       in_imm = 16'($urandom_range(0, 600) - 300);
          default: in_imm = 16'($urandom_range(0, 20) - 10);
        endcase
        in_last  = (n_sent == 199);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid8 && out_ready) begin
        chk("rand_expected_word", 32'(q_word.size() != 0), 32'(1));
        if (q_word.size() != 0) chk("rand_word", 32'(out_word8), 32'(q_word.pop_front()));
        chk("rand_addr", 32'(out_addr8), 32'(exp_addr));
        exp_addr = exp_addr + 8'd1;
      end
      acc = in_valid && in_ready8;
      if (acc) begin
        ref_enc(int'(in_mnem), int'(in_ra), int'(in_rb), int'(in_cond), in_imm, ok, w);
        if (ok) q_word.push_back(w[15:0]);
        else exp_err++;
        n_sent++;
      end
      if (done8) fin = 1'b1;
      tick;
      if (acc) begin in_valid = 1'b0; in_last = 1'b0; end
    end
    chk("rand_finished", 32'(fin), 32'(1));
    chk("rand_all_emitted", 32'(q_word.size()), 32'(0));
    chk("rand_err_count", 32'(err_count8), 32'((exp_err > 255) ? 255 : exp_err));
    chk("rand_err", 32'(err8), 32'(exp_err > 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
